fft_pingpong_buffer: RTL
========================

// Module: fft_pingpong_buffer
// PURPOSE
//  Parametrised ping-pong (double-buffered) complex sample store for the FP4 FFT datapath.
//  Provides two banks of DEPTH words: butterflies read the read bank and write the other bank.
//  The bank roles swap once per FFT stage, and the block counts stages to signal completion.
//  Adds a handshaked run/clear sequencer, registered reads with valid flags, and write-collision flagging.
// PARAMETERS
//  DATA_W      8                Word width, must be even; [DATA_W/2-1:0] = real, [DATA_W-1:DATA_W/2] = imag
//  DEPTH       32               Words per bank
//  ADDR_W      $clog2(DEPTH)    Address width
//  NUM_STAGES  5                Bank swaps per FFT run (log2 N)
// PORTS
//  clk           in   1                      Clock, rising edge
//  rst           in   1                      Asynchronous active-low reset
//  start         in   1                      Pulse: begin an FFT run (accepted in IDLE only)
//  swap_req      in   1                      Pulse: end of stage, swap banks (accepted in RUN only)
//  clr_req       in   1                      Pulse: zero the current write bank (accepted in IDLE only)
//  rd_en_0/1     in   1                      Read enable, port 0/1
//  rd_addr_0/1   in   ADDR_W                 Read address, port 0/1
//  rd_data_0/1   out  DATA_W                 Registered read data, port 0/1
//  rd_valid_0/1  out  1                      rd_data_0/1 holds data for the previous cycle's rd_en
//  wr_en_0/1     in   1                      Write enable, port 0/1
//  wr_addr_0/1   in   ADDR_W                 Write address, port 0/1
//  wr_data_0/1   in   DATA_W                 Write data, port 0/1
//  rd_bank       out  1                      Current read bank; write bank = ~rd_bank
//  stage_cnt     out  $clog2(NUM_STAGES+1)   Swaps completed in the current run
//  busy          out  1                      High in RUN or CLEAR
//  done          out  1                      1-cycle pulse on the final swap of a run
//  clr_done      out  1                      1-cycle pulse when CLEAR finishes
//  wr_collision  out  1                      1-cycle pulse: both write ports hit the same address
// BEHAVIOUR
//  Reset (async, rst=0):
//   - All outputs go to 0; FSM goes to IDLE; both banks are zeroed (flop storage).
//   - Reset mid-run or mid-clear aborts immediately; no done or clr_done pulse is issued.
//  FSM states: IDLE, RUN, CLEAR.
//   - IDLE: start -> RUN, rd_bank<=0, stage_cnt<=0.
//   - IDLE: clr_req -> CLEAR.
//   - IDLE: start and clr_req together -> start wins; clr_req is dropped.
//   - RUN: swap_req toggles rd_bank and increments stage_cnt at the edge.
//   - RUN: on the swap where stage_cnt==NUM_STAGES-1, done=1 for one cycle, stage_cnt<=NUM_STAGES, FSM -> IDLE.
//   - stage_cnt holds its value in IDLE until the next start.
//   - CLEAR: an internal counter writes 0 to write-bank address 0..DEPTH-1, one word per cycle.
//     This takes exactly DEPTH cycles; clr_done pulses in the last cycle, then FSM -> IDLE.
//   - Ignored requests: start/clr_req outside IDLE; swap_req outside RUN.
//  Reads:
//   - Always served from bank rd_bank, in every state; latency is 1 cycle.
//   - rd_valid_x <= rd_en_x. rd_data_x is updated only when rd_en_x=1 and holds otherwise.
//   - A read issued in the same cycle as an accepted swap uses the pre-swap bank.
//   - Address >= DEPTH returns 0 with rd_valid still asserted.
//  Writes:
//   - Always target bank ~rd_bank; taken in IDLE and RUN, ignored entirely in CLEAR.
//   - A write in the same cycle as an accepted swap lands in the pre-swap write bank.
//     It is therefore readable from the first cycle after the swap.
//   - Both ports to the same address: port 0 data is stored and wr_collision=1 for that cycle.
//   - Address >= DEPTH: the write is dropped, with no collision flag.
//  Real and imag halves are stored and returned unmodified; no arithmetic is performed.
// TESTING
//  T1 Reset values:
//     - Stimulus: rst=0 mid-CLEAR, then release.
//     - Required: all outputs 0; FSM IDLE; reading addr 0..31 of both banks returns 8'h00.
//  T2 Load, swap, read back:
//     - Stimulus: IDLE; write 8'hA5 to addr 3 (port 0) and 8'h3C to addr 30 (port 1); start; swap_req.
//     - Required: rd_bank=1; next-cycle reads return 8'hA5 and 8'h3C with rd_valid=1.
//  T3 Full run:
//     - Stimulus: start, then 5 swap_req pulses spaced 4 cycles apart.
//     - Required: stage_cnt 1..5; done high only on the 5th-swap cycle; busy falls the next cycle; rd_bank=1.
//  T4 Collision:
//     - Stimulus: wr_en_0=wr_en_1=1, both addr 7, data 8'h11 / 8'h22.
//     - Required: wr_collision pulses once; addr 7 later reads 8'h11.
//  T5 Clear:
//     - Stimulus: fill the write bank with 8'hFF; clr_req; also drive wr_en_0 during CLEAR.
//     - Required: busy for exactly 32 cycles; clr_done once; every word reads 0 after swap; the CLEAR-time write is absent.
//  T6 Swap-edge hazard:
//     - Stimulus: write addr 5 = 8'h5A and read addr 5 in the same cycle as swap_req.
//     - Required: the read returns the old read-bank value; a read of addr 5 on the next cycle returns 8'h5A.

Source files
------------

// File: rtl/fft_pingpong_buffer.sv
// Ping-pong complex sample store for the FP4 FFT datapath.
// Two banks of DEPTH words: reads come from bank rd_bank, writes go to the
// other bank. Banks swap once per stage; a small sequencer handles FFT runs
// and bank clearing. All outputs are registered.
module fft_pingpong_buffer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NUM_STAGES = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              swap_req,
    input  logic                              clr_req,
    input  logic                              rd_en_0,
    input  logic [ADDR_W-1:0]                 rd_addr_0,
    output logic [DATA_W-1:0]                 rd_data_0,
    output logic                              rd_valid_0,
    input  logic                              rd_en_1,
    input  logic [ADDR_W-1:0]                 rd_addr_1,
    output logic [DATA_W-1:0]                 rd_data_1,
    output logic                              rd_valid_1,
    input  logic                              wr_en_0,
    input  logic [ADDR_W-1:0]                 wr_addr_0,
    input  logic [DATA_W-1:0]                 wr_data_0,
    input  logic                              wr_en_1,
    input  logic [ADDR_W-1:0]                 wr_addr_1,
    input  logic [DATA_W-1:0]                 wr_data_1,
    output logic                              rd_bank,
    output logic [$clog2(NUM_STAGES+1)-1:0]   stage_cnt,
    output logic                              busy,
    output logic                              done,
    output logic                              clr_done,
    output logic                              wr_collision
);

    localparam int SW = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [2][DEPTH];

    logic                wr_bank;
    logic                wr_ok_0;
    logic                wr_ok_1;
    logic                wr_coll;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Write qualification: writes are dropped during CLEAR and when out of range
    always_comb begin
        wr_bank = ~rd_bank;
        wr_ok_0 = wr_en_0 && in_range(wr_addr_0) && (state != CLEAR);
        wr_ok_1 = wr_en_1 && in_range(wr_addr_1) && (state != CLEAR);
        wr_coll = wr_ok_0 && wr_ok_1 && (wr_addr_0 == wr_addr_1);
    end

    // Sequencer: run/swap/stage counting and the clear sweep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            stage_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            clr_done  <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            done     <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rd_bank   <= 1'b0;
                        stage_cnt <= '0;
                    end else if (clr_req) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_cnt  <= '0;
                        clr_done <= (DEPTH == 1);
                    end
                end
                RUN: begin
                    if (swap_req) begin
                        rd_bank   <= ~rd_bank;
                        stage_cnt <= stage_cnt + SW'(1);
                        if (stage_cnt == SW'(NUM_STAGES - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    // pulse is registered one cycle early so it lines up with the last sweep word
                    clr_done <= (clr_cnt == ADDR_W'(DEPTH - 2));
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank storage: clear sweep or dual-port writes into the write bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_collision <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    mem[b][a] <= '0;
                end
            end
        end else begin
            wr_collision <= wr_coll;
            if (state == CLEAR) begin
                mem[wr_bank][clr_cnt] <= '0;
            end else begin
                if (wr_ok_1 && !wr_coll) mem[wr_bank][wr_addr_1] <= wr_data_1;
                if (wr_ok_0)             mem[wr_bank][wr_addr_0] <= wr_data_0;
            end
        end
    end

    // Registered reads from the current read bank; data holds when not enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_0  <= '0;
            rd_data_1  <= '0;
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
        end else begin
            rd_valid_0 <= rd_en_0;
            rd_valid_1 <= rd_en_1;
            if (rd_en_0) rd_data_0 <= in_range(rd_addr_0) ? mem[rd_bank][rd_addr_0] : '0;
            if (rd_en_1) rd_data_1 <= in_range(rd_addr_1) ? mem[rd_bank][rd_addr_1] : '0;
        end
    end

endmodule
